tail_light_mode_ctrl: RTL

Mode sequencer and arbiter for the tail-light LED pattern datapath. It takes raw driver request levels and a slow step tick, and debounces and prioritises the requests. It selects one active lighting mode, enforces a minimum dwell per mode, and drives the step index that the pattern generators, side LEDs and seven-segment code selector consume. It replaces direct switch-to-mode decoding at the top level.

---
 rtl/tail_light_mode_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tail_light_mode_ctrl.sv
// Tail-light mode sequencer: debounces driver requests, arbitrates one mode with dwell, drives the step index.
// Optional turn-signal timeout is compiled in with `define AUTO_CANCEL_EN.
module tail_light_req_deb #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic lvl_o
);
  logic        s1_q, s2_q, lvl_q;
  logic [15:0] cnt_q;

  // Counter only runs while the synced value disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= req_i;
      s2_q <= s1_q;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 16'(DEB_CYCLES)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign lvl_o = lvl_q;
endmodule

module tail_light_mode_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned MIN_STEPS  = 4,
  parameter int unsigned STEP_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_hazard_i,
  input  logic       req_brake_i,
  input  logic       req_left_i,
  input  logic       req_right_i,
  input  logic       req_reverse_i,
  input  logic       tick_i,
  output logic [2:0] mode_o,
  output logic [1:0] step_o,
  output logic       mode_changed_o,
  output logic [7:0] disp_code_o
);
  localparam int NUM_REQ = 5;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  state_e       state_q, state_d;
  logic [2:0]   mode_q, mode_d, cand, nxt_mode;
  logic [1:0]   step_q, step_d;
  logic [7:0]   dwell_q, dwell_d, dwell_inc;
  logic         chg_q, load, wrap, preempt, lft, rgt;
  logic [7:0]   disp_q;
  logic [NUM_REQ-1:0] req_raw, deb;

  // Lane order: 0 hazard, 1 brake, 2 left, 3 right, 4 reverse
  assign req_raw = {req_reverse_i, req_right_i, req_left_i, req_brake_i, req_hazard_i};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_deb
    tail_light_req_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .req_i(req_raw[i]),
      .lvl_o(deb[i])
    );
  end

`ifdef AUTO_CANCEL_EN
  logic [1:0] mask_q, mask_d;
  logic [4:0] cyc_q, cyc_d;
  logic       turn_held, cancel;

  assign lft       = deb[2] & ~mask_q[0];
  assign rgt       = deb[3] & ~mask_q[1];
  assign turn_held = (mode_q == 3'd2 && deb[2]) || (mode_q == 3'd3 && deb[3]);
  assign cancel    = turn_held && wrap && (cyc_q >= 5'd15);
  // A cancelled turn stays masked until its debounced level drops.
  assign mask_d    = (mask_q & deb[3:2]) |
                     ((state_q == RUN && !preempt && cancel) ? {mode_q == 3'd3, mode_q == 3'd2} : 2'b00);

  always_comb begin
    cyc_d = cyc_q;
    if (load)
      cyc_d = '0;
    else if (wrap && (mode_q == 3'd2 || mode_q == 3'd3) && cyc_q < 5'd16)
      cyc_d = cyc_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      cyc_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cyc_q  <= cyc_d;
    end
  end
`else
  assign lft = deb[2];
  assign rgt = deb[3];
`endif

  always_comb begin
    cand = 3'd0;
    if (deb[0] || (lft && rgt)) cand = 3'd5;
    else if (deb[1])            cand = 3'd1;
    else if (deb[4])            cand = 3'd4;
    else if (lft)               cand = 3'd2;
    else if (rgt)               cand = 3'd3;
  end

  assign wrap      = tick_i && (step_q == 2'(STEP_MAX));
  assign preempt   = (cand == 3'd5) && (mode_q != 3'd5);
  assign dwell_inc = (dwell_q >= 8'(MIN_STEPS)) ? dwell_q : dwell_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    load     = 1'b0;
    nxt_mode = cand;
    if (tick_i && state_q != IDLE) begin
      step_d  = wrap ? 2'd0 : step_q + 2'd1;
      dwell_d = dwell_inc;
    end
    unique case (state_q)
      IDLE: if (cand != 3'd0) load = 1'b1;
      RUN: begin
        if (preempt) load = 1'b1;
`ifdef AUTO_CANCEL_EN
        else if (cancel) begin
          load     = 1'b1;
          nxt_mode = 3'd0;
        end
`endif
        else if (cand != mode_q) state_d = PEND;
      end
      PEND: begin
        if (preempt)                                  load = 1'b1;
        else if (cand == mode_q)                      state_d = RUN;
        else if (wrap && dwell_inc >= 8'(MIN_STEPS))  load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Every load changes the mode, so a reload with the same value cannot pulse.
    if (load) begin
      mode_d  = nxt_mode;
      step_d  = 2'd0;
      dwell_d = '0;
      state_d = (nxt_mode == 3'd0) ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      chg_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      chg_q   <= load;
      disp_q  <= {1'b0, mode_d, 2'b00, step_d};
    end
  end

  assign mode_o         = mode_q;
  assign step_o         = step_q;
  assign mode_changed_o = chg_q;
  assign disp_code_o    = disp_q;
endmodule
